snitch_icache_refill_engine: RTL and testbench
==============================================

// Module: snitch_icache_refill_engine
// PURPOSE
// - Responder for the icache refill request/response channel: accepts one line-refill request (addr, id),
//   splits it into BEATS = LINE_WIDTH/MEM_DW word reads on a narrow memory port, assembles the line,
//   and returns it with the request id and an OR-ed error flag.
// - Sits between the icache miss handler and the L2/instruction memory; one line in flight at a time.
// - Beat reads are pipelined, with up to MAX_OUT beats outstanding.
// PARAMETERS
// - FETCH_AW    32   refill address width (byte address)
// - LINE_WIDTH  128  cache line width in bits; must equal MEM_DW * 2^n, n>=0
// - MEM_DW      32   memory beat width in bits; power of two, >=8
// - PENDING_IW  2    refill id width
// - MAX_OUT     2    maximum outstanding beat reads; 1..BEATS
// PORTS
// - clk_i           in   1           clock; single clock domain
// - rst_i           in   1           reset, synchronous, active-high
// - req_addr_i      in   FETCH_AW    refill byte address; low LINE_ALIGN bits ignored
// - req_id_i        in   PENDING_IW  refill id
// - req_valid_i     in   1           request valid
// - req_ready_o     out  1           request ready (=1 only in IDLE)
// - rsp_data_o      out  LINE_WIDTH  assembled line, beat k at [k*MEM_DW +: MEM_DW]
// - rsp_error_o     out  1           OR of all beat errors of this line
// - rsp_id_o        out  PENDING_IW  id captured at request
// - rsp_valid_o     out  1           response valid
// - rsp_ready_i     in   1           response ready
// - mem_req_addr_o  out  FETCH_AW    beat byte address
// - mem_req_valid_o out  1           beat read valid
// - mem_req_ready_i in   1           beat read accepted
// - mem_rsp_data_i  in   MEM_DW      beat data; responses in issue order
// - mem_rsp_error_i in   1           beat error
// - mem_rsp_valid_i in   1           beat response valid
// - mem_rsp_ready_o out  1           beat response ready (=1 only in BUSY)
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge):
//   - state=IDLE; all counters, data, error, id registers cleared to 0.
//   - Outputs: req_ready_o=1; rsp_valid_o=0; mem_req_valid_o=0; mem_rsp_ready_o=0; data/addr/id/error=0.
//   - Reset mid-line discards all progress. Memory must be reset in the same cycle; late beats are not tolerated.
// - LINE_ALIGN = log2(LINE_WIDTH/8); BEAT_ALIGN = log2(MEM_DW/8).
// - Counters: issue_cnt, recv_cnt and out_cnt, each $clog2(BEATS+1) wide.
// - IDLE:
//   - On req_valid_i && req_ready_o: capture base = {addr[FETCH_AW-1:LINE_ALIGN], '0} and id.
//   - Clear error, data and counters; go to BUSY.
// - BUSY:
//   - mem_req_valid_o = (issue_cnt<BEATS) && (out_cnt<MAX_OUT).
//   - mem_req_addr_o = base + (issue_cnt << BEAT_ALIGN); computed modulo 2^FETCH_AW, no carry out.
//   - A beat is issued on mem_req_valid_o && mem_req_ready_i; then issue_cnt++.
//   - Each mem_rsp handshake writes data slice recv_cnt, sets error |= mem_rsp_error_i, and does recv_cnt++.
//   - out_cnt = issue_cnt - recv_cnt, tracked in a register.
//   - Issue and receive in the same cycle leave out_cnt unchanged, and the issue is still allowed at out_cnt==MAX_OUT.
//   - When the last beat (recv_cnt==BEATS-1) is received, go to RESP.
// - RESP:
//   - rsp_valid_o=1. data/error/id are held stable until rsp_ready_i.
//   - On handshake go to IDLE; the next request is accepted no earlier than the following cycle.
// - Valid stability: mem_req_valid_o/addr and rsp_valid_o/payload never change while valid && !ready.
// - Latency with zero-wait memory: request accept at cycle 0, first beat at cycle 1, rsp_valid_o at cycle BEATS+2.
// - An error beat does not abort the line; all BEATS beats are always fetched.
// - mem_rsp_valid_i outside BUSY is a protocol violation; simulation asserts on it.
// STRUCTURE
// - Parameters FETCH_AW, LINE_WIDTH and PENDING_IW come from snitch_icache_pkg::config_t (CFG).
// - Add a MEM_DW field and a state enum refill_state_e {IDLE, BUSY, RESP} to snitch_icache_pkg.
// - Single module with counters and FSM inline; no sub-module. Elaboration asserts on the parameter legality rules.
// TESTING
// - Zero-wait: addr 0x1000_0014, id 2 -> beats at 0x1000_0010/14/18/1C; rsp at cycle 6, id 2, data = 4 beats packed, error 0.
// - Beat 2 carries error=1 -> all 4 beats fetched; rsp_error_o=1; other slices correct.
// - mem_req_ready_i low 3 cycles, MAX_OUT=2 with delayed responses -> never more than 2 outstanding; addr held stable.
// - rsp_ready_i low 5 cycles -> rsp held stable, req_ready_o=0, no mem_req; then IDLE, next request accepted.
// - Address 0xFFFF_FFF0 -> beats wrap correctly (0xFFFF_FFF0..FC), no carry out.
// - rst_i asserted mid-BUSY after 2 beats -> next cycle IDLE, all outputs at reset values; fresh request completes correctly.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// Shared configuration and state types for the snitch instruction cache.
// The refill engine takes its widths from config_t and exposes its FSM
// state using refill_state_e.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;    // refill byte address width
    int unsigned LINE_WIDTH;  // cache line width in bits
    int unsigned PENDING_IW;  // refill id width
    int unsigned MEM_DW;      // memory beat width in bits
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    FETCH_AW:   32,
    LINE_WIDTH: 128,
    PENDING_IW: 2,
    MEM_DW:     32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } refill_state_e;

  // True for 1, 2, 4, 8, ...; used by the parameter legality checks.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/snitch_icache_refill_engine.sv
// Line refill responder: accepts one refill request, reads the line as
// BEATS narrow beats with up to MAX_OUT reads outstanding, assembles the
// beats in order and returns the line with its id and an OR-ed error flag.
//
// Handshake rule for every channel here: a transfer happens on a rising
// clk_i edge where valid and ready are both high; once valid is raised, it
// and its payload stay unchanged until that transfer happens.
module snitch_icache_refill_engine
  import snitch_icache_pkg::*;
#(
  parameter config_t     CFG     = DEFAULT_CFG,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // refill request
  input  logic [CFG.FETCH_AW-1:0]   req_addr_i,
  input  logic [CFG.PENDING_IW-1:0] req_id_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  // refill response
  output logic [CFG.LINE_WIDTH-1:0] rsp_data_o,
  output logic                      rsp_error_o,
  output logic [CFG.PENDING_IW-1:0] rsp_id_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  // narrow memory port
  output logic [CFG.FETCH_AW-1:0]   mem_req_addr_o,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  input  logic [CFG.MEM_DW-1:0]     mem_rsp_data_i,
  input  logic                      mem_rsp_error_i,
  input  logic                      mem_rsp_valid_i,
  output logic                      mem_rsp_ready_o,
  // debug view of the FSM
  output refill_state_e             dbg_state_o
);

  localparam int unsigned AW         = CFG.FETCH_AW;
  localparam int unsigned LW         = CFG.LINE_WIDTH;
  localparam int unsigned DW         = CFG.MEM_DW;
  localparam int unsigned IW         = CFG.PENDING_IW;
  localparam int unsigned BEATS      = LW / DW;
  localparam int unsigned LINE_ALIGN = $clog2(LW / 8);
  localparam int unsigned BEAT_ALIGN = $clog2(DW / 8);
  localparam int unsigned CNT_W      = $clog2(BEATS + 1);

  // Clears the byte offset inside the line.
  localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << LINE_ALIGN) - AW'(1));

  // Parameter legality, checked at elaboration.
  if (!is_pow2(DW) || (DW < 8)) begin : g_bad_mem_dw
    $error("MEM_DW must be a power of two and at least 8");
  end
  if (((LW % DW) != 0) || !is_pow2(LW / DW)) begin : g_bad_line_width
    $error("LINE_WIDTH must be MEM_DW times a power of two");
  end
  if ((MAX_OUT < 1) || (MAX_OUT > BEATS)) begin : g_bad_max_out
    $error("MAX_OUT must lie in 1..BEATS");
  end
  if (LINE_ALIGN >= AW) begin : g_bad_fetch_aw
    $error("FETCH_AW too narrow for the line size");
  end

  refill_state_e    state_q;
  logic [AW-1:0]    base_q;
  logic [IW-1:0]    id_q;
  logic [LW-1:0]    data_q;
  logic             error_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] recv_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;

  logic issue_room;
  logic issue_fire;
  logic recv_fire;

  // A read may go out while a slot is free, or when a response retires one
  // in the same cycle. If valid rises only through that response and the
  // memory stalls, out_cnt drops on that edge, so valid holds next cycle.
  assign issue_room = (issue_cnt_q < CNT_W'(BEATS)) &&
                      ((out_cnt_q < CNT_W'(MAX_OUT)) || mem_rsp_valid_i);

  assign mem_req_valid_o = (state_q == BUSY) && issue_room;
  assign mem_req_addr_o  = base_q + (AW'(issue_cnt_q) << BEAT_ALIGN);
  assign mem_rsp_ready_o = (state_q == BUSY);
  assign req_ready_o     = (state_q == IDLE);
  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_data_o      = data_q;
  assign rsp_error_o     = error_q;
  assign rsp_id_o        = id_q;
  assign dbg_state_o     = state_q;

  assign issue_fire = mem_req_valid_o && mem_req_ready_i;
  assign recv_fire  = mem_rsp_valid_i && mem_rsp_ready_o;

  // FSM, beat counters and line assembly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      id_q        <= '0;
      data_q      <= '0;
      error_q     <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            base_q      <= req_addr_i & LINE_MASK;
            id_q        <= req_id_i;
            data_q      <= '0;
            error_q     <= 1'b0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            out_cnt_q   <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (issue_fire) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end
          if (recv_fire) begin
            // Responses return in issue order, so recv_cnt names the slice.
            for (int k = 0; k < BEATS; k++) begin
              if (recv_cnt_q == CNT_W'(k)) begin
                data_q[k*DW +: DW] <= mem_rsp_data_i;
              end
            end
            error_q    <= error_q | mem_rsp_error_i;
            recv_cnt_q <= recv_cnt_q + CNT_W'(1);
            if (recv_cnt_q == CNT_W'(BEATS - 1)) begin
              state_q <= RESP;
            end
          end
          if (issue_fire && !recv_fire) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
          end else if (!issue_fire && recv_fire) begin
            out_cnt_q <= out_cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat responses are only legal while a line is being fetched.
  a_rsp_only_in_busy : assert property (
    @(posedge clk_i) disable iff (rst_i) mem_rsp_valid_i |-> (state_q == BUSY)
  );

endmodule

// File: tb/tb_snitch_icache_refill_engine.sv
// Bench for snitch_icache_refill_engine: a memory model answers beat reads
// in order after a configurable delay; expected beat addresses and expected
// lines are queued when a request is accepted and compared as the DUT
// issues beats and returns lines.
module tb_snitch_icache_refill_engine;
  import snitch_icache_pkg::*;

  localparam config_t CFG     = DEFAULT_CFG;
  localparam int      MAX_OUT = 2;
  localparam int      AW      = 32;
  localparam int      LW      = 128;
  localparam int      DW      = 32;
  localparam int      IW      = 2;
  localparam int      BEATS   = LW / DW;
  localparam int      EXP_W   = LW + 1 + IW;  // {error, id, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] req_addr_i;
  logic [IW-1:0] req_id_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [LW-1:0] rsp_data_o;
  logic          rsp_error_o;
  logic [IW-1:0] rsp_id_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          mem_rsp_error_i;
  logic          mem_rsp_valid_i;
  logic          mem_rsp_ready_o;
  refill_state_e dbg_state_o;

  snitch_icache_refill_engine #(.CFG(CFG), .MAX_OUT(MAX_OUT)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_addr_i      (req_addr_i),
    .req_id_i        (req_id_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_error_o     (rsp_error_o),
    .rsp_id_o        (rsp_id_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_error_i (mem_rsp_error_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int unsigned   due;
  } beat_t;

  logic [EXP_W-1:0] exp_q[$];
  logic [AW-1:0]    exp_addr_q[$];
  beat_t            pend_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // memory model knobs
  int rsp_delay  = 1;
  int stall_cnt  = 0;
  bit rand_ready = 1'b0;
  bit rand_delay = 1'b0;
  int err_beat   = -1;
  int beat_idx   = 0;
  int recv_line  = 0;
  int out_tb     = 0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- memory model ----------------
  initial begin : mem_model
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] a;
    bit            iss;
    bit            rcv;
    int            d;
    prev_stall      = 1'b0;
    prev_addr       = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_error_i = 1'b0;
    forever begin
      @(negedge clk);
      mem_req_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : (stall_cnt == 0);
      if ((pend_q.size() > 0) && (pend_q[0].due <= cyc)) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = pend_q[0].data;
        mem_rsp_error_i = pend_q[0].err;
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_error_i = 1'b0;
      end
      #1;
      if (rst_i) begin
        // memory is reset together with the engine
        pend_q.delete();
        exp_addr_q.delete();
        out_tb     = 0;
        beat_idx   = 0;
        recv_line  = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("req_hold_valid", mem_req_valid_o, 1);
          check("req_hold_addr", mem_req_addr_o, prev_addr);
        end
        prev_stall = mem_req_valid_o && !mem_req_ready_i;
        prev_addr  = mem_req_addr_o;
        if (mem_req_valid_o && !mem_req_ready_i && (stall_cnt > 0)) stall_cnt--;
        rcv = mem_rsp_valid_i && mem_rsp_ready_o;
        iss = mem_req_valid_o && mem_req_ready_i;
        if (rcv) begin
          void'(pend_q.pop_front());
          recv_line++;
          out_tb--;
        end
        if (iss) begin
          if (exp_addr_q.size() == 0) begin
            check("beat_count", beat_idx, BEATS - 1);
          end else begin
            a = exp_addr_q.pop_front();
            check("beat_addr", mem_req_addr_o, a);
          end
          out_tb++;
          check("max_out", (out_tb > MAX_OUT), 0);
          d = rand_delay ? $urandom_range(1, 4) : rsp_delay;
          pend_q.push_back('{data: beat_data(mem_req_addr_o), err: (beat_idx == err_beat),
                             due: cyc + d});
          beat_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int eb,
                          output int unsigned acc_cyc);
    logic [AW-1:0] base;
    logic [LW-1:0] line;
    logic          err;
    bit            done;
    done    = 1'b0;
    acc_cyc = 0;
    base    = addr & ~32'h0000_000F;
    for (int k = 0; k < BEATS; k++) line[k*DW +: DW] = beat_data(base + AW'(4 * k));
    err = (eb >= 0) && (eb < BEATS);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_id_i    = id;
    for (int n = 0; (n < 50) && !done; n++) begin
      #1;
      if (req_ready_o) begin
        done     = 1'b1;
        acc_cyc  = cyc;
        err_beat = eb;
        beat_idx = 0;
        recv_line = 0;
        exp_q.push_back({err, id, line});
        for (int k = 0; k < BEATS; k++) exp_addr_q.push_back(base + AW'(4 * k));
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    check("req_accept", done, 1);
  endtask

  task automatic wait_rsp(input int hold, input int exp_lat, input int unsigned acc_cyc);
    logic [EXP_W-1:0] e;
    bit seen;
    seen = 1'b0;
    rsp_ready_i = 1'b0;
    for (int n = 0; (n < 200) && !seen; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_o) seen = 1'b1;
    end
    check("rsp_seen", seen, 1);
    if (!seen) return;
    if (exp_lat > 0) check("latency", cyc - acc_cyc, exp_lat);
    if (exp_q.size() == 0) begin
      check("exp_q_depth", exp_q.size(), 1);
      return;
    end
    e = exp_q[0];
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", rsp_valid_o, 1);
      check("hold_data", rsp_data_o, e[LW-1:0]);
      check("hold_id", rsp_id_o, e[LW+IW-1:LW]);
      check("hold_error", rsp_error_o, e[EXP_W-1]);
      check("hold_req_ready", req_ready_o, 0);
      check("hold_no_mem_req", mem_req_valid_o, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready_i = 1'b1;
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_data", rsp_data_o, e[LW-1:0]);
    check("rsp_id", rsp_id_o, e[LW+IW-1:LW]);
    check("rsp_error", rsp_error_o, e[EXP_W-1]);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    #1;
    check("idle_req_ready", req_ready_o, 1);
    check("idle_rsp_valid", rsp_valid_o, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready_o, 1);
    check({pfx, "_rsp_valid"}, rsp_valid_o, 0);
    check({pfx, "_mem_req_valid"}, mem_req_valid_o, 0);
    check({pfx, "_mem_rsp_ready"}, mem_rsp_ready_o, 0);
    check({pfx, "_rsp_data"}, rsp_data_o, 0);
    check({pfx, "_rsp_error"}, rsp_error_o, 0);
    check({pfx, "_rsp_id"}, rsp_id_o, 0);
    check({pfx, "_mem_addr"}, mem_req_addr_o, 0);
    check({pfx, "_state"}, dbg_state_o, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int unsigned acc;
    bit          hit;
    int          eb;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_id_i    = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;

    // zero-wait line, latency and beat addresses
    send_req(32'h1000_0014, 2'd2, -1, acc);
    wait_rsp(0, 6, acc);

    // error on beat 2 does not abort the line
    send_req(32'h2000_0040, 2'd1, 2, acc);
    wait_rsp(0, 6, acc);

    // stalled memory request channel with slow responses
    stall_cnt = 3;
    rsp_delay = 3;
    send_req(32'h3000_0108, 2'd3, -1, acc);
    wait_rsp(0, 0, acc);
    rsp_delay = 1;

    // response back-pressure, then an immediate follow-up request
    send_req(32'h4000_0020, 2'd0, 0, acc);
    wait_rsp(5, 0, acc);
    send_req(32'h4000_0030, 2'd1, 3, acc);
    wait_rsp(0, 6, acc);

    // top-of-address-space lines
    send_req(32'hFFFF_FFF0, 2'd2, -1, acc);
    wait_rsp(0, 6, acc);
    send_req(32'hFFFF_FFFE, 2'd3, 1, acc);
    wait_rsp(1, 0, acc);

    // reset after two beats have returned
    rsp_delay = 2;
    send_req(32'h5000_0080, 2'd1, -1, acc);
    hit = 1'b0;
    for (int n = 0; (n < 50) && !hit; n++) begin
      @(negedge clk);
      if (recv_line >= 2) hit = 1'b1;
    end
    check("mid_line_progress", hit, 1);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rsp_delay = 1;
    send_req(32'h5000_0090, 2'd1, -1, acc);
    wait_rsp(0, 6, acc);

    // random traffic
    rand_ready = 1'b1;
    rand_delay = 1'b1;
    for (int t = 0; t < 10; t++) begin
      eb = $urandom_range(0, 7);
      send_req($urandom, IW'($urandom_range(0, 3)), eb, acc);
      wait_rsp($urandom_range(0, 3), 0, acc);
    end
    rand_ready = 1'b0;
    rand_delay = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_lines_left", exp_q.size(), 0);
    check("sb_beats_left", exp_addr_q.size(), 0);
    check("pending_left", pend_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // hard time limit
  initial begin : watchdog
    #400000;
    n_errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "time limit");
  end

endmodule
